// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, FSM states,
// ctl/alu_op bit positions and opcode classification helpers.
package cpu_pkg;

   localparam int CTL_W = 16;
   localparam int ALU_W = 13;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ST_RST  = 4'd0;
   localparam logic [3:0] ST_F0   = 4'd1;
   localparam logic [3:0] ST_F1   = 4'd2;
   localparam logic [3:0] ST_F2   = 4'd3;
   localparam logic [3:0] ST_F3   = 4'd4;
   localparam logic [3:0] ST_E1   = 4'd5;
   localparam logic [3:0] ST_E2   = 4'd6;
   localparam logic [3:0] ST_E3   = 4'd7;
   localparam logic [3:0] ST_E4   = 4'd8;
   localparam logic [3:0] ST_HALT = 4'd9;

   localparam int CTL_PCIN     = 15;
   localparam int CTL_PCOUT    = 14;
   localparam int CTL_IRIN     = 13;
   localparam int CTL_YIN      = 12;
   localparam int CTL_ZIN      = 11;
   localparam int CTL_MARIN    = 10;
   localparam int CTL_MDRIN    = 9;
   localparam int CTL_MDROUT   = 8;
   localparam int CTL_HIIN     = 7;
   localparam int CTL_HIOUT    = 6;
   localparam int CTL_LOIN     = 5;
   localparam int CTL_LOOUT    = 4;
   localparam int CTL_INCPC    = 3;
   localparam int CTL_ZHIGHOUT = 2;
   localparam int CTL_ZLOWOUT  = 1;
   localparam int CTL_READ     = 0;

   localparam int ALU_AND  = 12;
   localparam int ALU_OR   = 11;
   localparam int ALU_NEG  = 10;
   localparam int ALU_NOT  = 9;
   localparam int ALU_SUB  = 8;
   localparam int ALU_ADD  = 7;
   localparam int ALU_MUL  = 6;
   localparam int ALU_ROR  = 5;
   localparam int ALU_DIV  = 4;
   localparam int ALU_SHL  = 3;
   localparam int ALU_SHR  = 2;
   localparam int ALU_SHRA = 1;
   localparam int ALU_ROL  = 0;

   typedef enum logic [2:0] {
      CLS_TWO,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   // Selects which execute micro-sequence an opcode follows.
   function automatic op_class_t op_class(input logic [4:0] opc);
      op_class_t c;
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL: c = CLS_TWO;
         OP_MUL, OP_DIV:                  c = CLS_MULDIV;
         OP_NEG, OP_NOT:                  c = CLS_UNARY;
         OP_NOP:                          c = CLS_NOP;
         OP_HALT:                         c = CLS_HALT;
         default:                         c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

   function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] opc);
      logic [ALU_W-1:0] r;
      r = '0;
      case (opc)
         OP_AND:  r[ALU_AND]  = 1'b1;
         OP_OR:   r[ALU_OR]   = 1'b1;
         OP_NEG:  r[ALU_NEG]  = 1'b1;
         OP_NOT:  r[ALU_NOT]  = 1'b1;
         OP_SUB:  r[ALU_SUB]  = 1'b1;
         OP_ADD:  r[ALU_ADD]  = 1'b1;
         OP_MUL:  r[ALU_MUL]  = 1'b1;
         OP_ROR:  r[ALU_ROR]  = 1'b1;
         OP_DIV:  r[ALU_DIV]  = 1'b1;
         OP_SHL:  r[ALU_SHL]  = 1'b1;
         OP_SHR:  r[ALU_SHR]  = 1'b1;
         OP_SHRA: r[ALU_SHRA] = 1'b1;
         OP_ROL:  r[ALU_ROL]  = 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Turns a 4-bit register field into a gated one-hot R0..R15 strobe vector.
module reg_field_decoder (
   input  logic [3:0]  idx,
   input  logic        en,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch F0..F3, per-opcode execute E1..E4,
// fetch timeout and illegal-opcode fault, retired-instruction counter.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 16,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic [15:0]      reg_in,
   output logic [15:0]      reg_out,
   output logic [CTL_W-1:0] ctl,
   output logic [ALU_W-1:0] alu_op,
   output logic             run,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = $clog2(FETCH_TIMEOUT) + 1;

   logic [3:0]        state;
   logic [3:0]        nxt_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [4:0]        opc;
   logic [3:0]        ra;
   logic [3:0]        rb;
   logic [3:0]        rc;
   logic              unused_ir;
   op_class_t         cls;
   logic              timeout_hit;
   logic              illegal_hit;
   logic              last_exec;
   logic              out_en;
   logic              in_en;
   logic [3:0]        out_idx;
   logic [3:0]        in_idx;

   assign opc       = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];
   assign cls       = op_class(opc);

   assign timeout_hit = (state == ST_F2) && !mem_ready &&
                        (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1));
   assign illegal_hit = (state == ST_E1) && (cls == CLS_ILLEGAL);

   // Final execute cycle differs per class; this is where an instruction retires.
   assign last_exec = ((state == ST_E1) && (cls == CLS_NOP))    ||
                      ((state == ST_E2) && (cls == CLS_UNARY))  ||
                      ((state == ST_E3) && (cls == CLS_TWO))    ||
                      ((state == ST_E4) && (cls == CLS_MULDIV));

   always_comb begin
      nxt_state = state;
      case (state)
         ST_RST: nxt_state = ST_F0;
         ST_F0:  nxt_state = ST_F1;
         ST_F1:  nxt_state = ST_F2;
         ST_F2: begin
            if (mem_ready)        nxt_state = ST_F3;
            else if (timeout_hit) nxt_state = ST_HALT;
            else                  nxt_state = ST_F2;
         end
         ST_F3:  nxt_state = ST_E1;
         ST_E1: begin
            case (cls)
               CLS_TWO, CLS_MULDIV, CLS_UNARY: nxt_state = ST_E2;
               CLS_HALT:                       nxt_state = ST_HALT;
               default:                        nxt_state = ST_F0;
            endcase
         end
         ST_E2:  nxt_state = (cls == CLS_TWO || cls == CLS_MULDIV) ? ST_E3 : ST_F0;
         ST_E3:  nxt_state = (cls == CLS_MULDIV) ? ST_E4 : ST_F0;
         ST_E4:  nxt_state = ST_F0;
         ST_HALT: nxt_state = ST_HALT;
         default: nxt_state = ST_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= ST_RST;
         wait_cnt <= '0;
         err      <= 1'b0;
         retired  <= '0;
      end else begin
         state <= nxt_state;
         if ((state == ST_F2) && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                                wait_cnt <= '0;
         if (timeout_hit || illegal_hit) err <= 1'b1;
         if (last_exec) retired <= retired + CNT_W'(1);
      end
   end

   // Output decode depends only on state and ir so the machine stays Moore.
   always_comb begin
      ctl     = '0;
      alu_op  = '0;
      out_en  = 1'b0;
      out_idx = rb;
      in_en   = 1'b0;
      in_idx  = ra;
      case (state)
         ST_F0: begin
            ctl[CTL_PCOUT] = 1'b1;
            ctl[CTL_MARIN] = 1'b1;
            ctl[CTL_INCPC] = 1'b1;
            ctl[CTL_ZIN]   = 1'b1;
         end
         ST_F1: begin
            ctl[CTL_ZLOWOUT] = 1'b1;
            ctl[CTL_PCIN]    = 1'b1;
         end
         ST_F2: begin
            ctl[CTL_READ]  = 1'b1;
            ctl[CTL_MDRIN] = 1'b1;
         end
         ST_F3: begin
            ctl[CTL_MDROUT] = 1'b1;
            ctl[CTL_IRIN]   = 1'b1;
         end
         ST_E1: begin
            case (cls)
               CLS_TWO: begin
                  out_en       = 1'b1;
                  out_idx      = rb;
                  ctl[CTL_YIN] = 1'b1;
               end
               CLS_MULDIV: begin
                  out_en       = 1'b1;
                  out_idx      = ra;
                  ctl[CTL_YIN] = 1'b1;
               end
               CLS_UNARY: begin
                  out_en       = 1'b1;
                  out_idx      = rb;
                  alu_op       = alu_onehot(opc);
                  ctl[CTL_ZIN] = 1'b1;
               end
               default: ;
            endcase
         end
         ST_E2: begin
            case (cls)
               CLS_TWO: begin
                  out_en       = 1'b1;
                  out_idx      = rc;
                  alu_op       = alu_onehot(opc);
                  ctl[CTL_ZIN] = 1'b1;
               end
               CLS_MULDIV: begin
                  out_en       = 1'b1;
                  out_idx      = rb;
                  alu_op       = alu_onehot(opc);
                  ctl[CTL_ZIN] = 1'b1;
               end
               CLS_UNARY: begin
                  ctl[CTL_ZLOWOUT] = 1'b1;
                  in_en            = 1'b1;
                  in_idx           = ra;
               end
               default: ;
            endcase
         end
         ST_E3: begin
            if (cls == CLS_TWO) begin
               ctl[CTL_ZLOWOUT] = 1'b1;
               in_en            = 1'b1;
               in_idx           = ra;
            end else if (cls == CLS_MULDIV) begin
               ctl[CTL_ZLOWOUT] = 1'b1;
               ctl[CTL_LOIN]    = 1'b1;
            end
         end
         ST_E4: begin
            if (cls == CLS_MULDIV) begin
               ctl[CTL_ZHIGHOUT] = 1'b1;
               ctl[CTL_HIIN]     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign run = (state != ST_HALT);

   reg_field_decoder u_out_dec (
      .idx    (out_idx),
      .en     (out_en),
      .onehot (reg_out)
   );

   reg_field_decoder u_in_dec (
      .idx    (in_idx),
      .en     (in_en),
      .onehot (reg_in)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: a per-instruction micro-sequence model predicts every
// cycle's strobes, run, err and retired, and compares against the DUT.
module tb_control_sequencer;

   localparam int TO    = 16;
   localparam int CW    = 4;

   localparam logic [15:0] C_PCIN   = 16'h8000;
   localparam logic [15:0] C_PCOUT  = 16'h4000;
   localparam logic [15:0] C_IRIN   = 16'h2000;
   localparam logic [15:0] C_YIN    = 16'h1000;
   localparam logic [15:0] C_ZIN    = 16'h0800;
   localparam logic [15:0] C_MARIN  = 16'h0400;
   localparam logic [15:0] C_MDRIN  = 16'h0200;
   localparam logic [15:0] C_MDROUT = 16'h0100;
   localparam logic [15:0] C_HIIN   = 16'h0080;
   localparam logic [15:0] C_LOIN   = 16'h0020;
   localparam logic [15:0] C_INCPC  = 16'h0008;
   localparam logic [15:0] C_ZHI    = 16'h0004;
   localparam logic [15:0] C_ZLO    = 16'h0002;
   localparam logic [15:0] C_READ   = 16'h0001;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic [31:0]   ir = '0;
   logic          mem_ready = 1'b0;
   logic [15:0]   reg_in;
   logic [15:0]   reg_out;
   logic [15:0]   ctl;
   logic [12:0]   alu_op;
   logic          run;
   logic          err;
   logic [CW-1:0] retired;

   always #5 clk = ~clk;

   control_sequencer #(.FETCH_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk       (clk),
      .clr       (clr),
      .ir        (ir),
      .mem_ready (mem_ready),
      .reg_in    (reg_in),
      .reg_out   (reg_out),
      .ctl       (ctl),
      .alu_op    (alu_op),
      .run       (run),
      .err       (err),
      .retired   (retired)
   );

   typedef struct {
      logic [15:0]   rin;
      logic [15:0]   rout;
      logic [15:0]   ctl;
      logic [12:0]   alu;
      logic          run;
      logic          err;
      logic [CW-1:0] ret;
      logic          mr;
      logic [31:0]   ir_next;
   } rec_t;

   rec_t          q[$];
   logic          m_err = 1'b0;
   logic [CW-1:0] m_ret = '0;
   logic [31:0]   m_ir = '0;
   int            n_total = 0;
   int            n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] oh(input logic [3:0] idx);
      return 16'(1) << idx;
   endfunction

   // 1: two-operand, 2: mul/div, 3: neg/not, 4: nop, 5: halt, 0: illegal
   function automatic int kind(input logic [4:0] op);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return 1;
         5'd15, 5'd16: return 2;
         5'd17, 5'd18: return 3;
         5'd26:        return 4;
         5'd27:        return 5;
         default:      return 0;
      endcase
   endfunction

   function automatic logic [12:0] alu_mask(input logic [4:0] op);
      case (op)
         5'd5:    return 13'h1000;
         5'd6:    return 13'h0800;
         5'd17:   return 13'h0400;
         5'd18:   return 13'h0200;
         5'd4:    return 13'h0100;
         5'd3:    return 13'h0080;
         5'd15:   return 13'h0040;
         5'd7:    return 13'h0020;
         5'd16:   return 13'h0010;
         5'd11:   return 13'h0008;
         5'd9:    return 13'h0004;
         5'd10:   return 13'h0002;
         5'd8:    return 13'h0001;
         default: return 13'h0000;
      endcase
   endfunction

   task automatic push(input logic [15:0] rin, input logic [15:0] rout, input logic [15:0] c,
                       input logic [12:0] alu, input logic rn, input logic mr);
      rec_t r;
      r.rin = rin; r.rout = rout; r.ctl = c; r.alu = alu; r.run = rn;
      r.err = m_err; r.ret = m_ret; r.mr = mr; r.ir_next = m_ir;
      q.push_back(r);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_halt(input int n);
      for (int i = 0; i < n; i++) push('0, '0, '0, '0, 1'b0, rbit());
   endtask

   // Expected cycles for one fetch+execute; waits = F2 cycles with mem_ready low.
   task automatic build(input logic [31:0] instr, input int waits);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
      push('0, '0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, '0, 1'b1, rbit());
      push('0, '0, C_ZLO | C_PCIN, '0, 1'b1, rbit());
      if (waits >= TO) begin
         for (int i = 0; i < TO; i++) push('0, '0, C_READ | C_MDRIN, '0, 1'b1, 1'b0);
         m_err = 1'b1;
         push_halt(3);
         return;
      end
      for (int i = 0; i < waits; i++) push('0, '0, C_READ | C_MDRIN, '0, 1'b1, 1'b0);
      push('0, '0, C_READ | C_MDRIN, '0, 1'b1, 1'b1);
      m_ir = instr;
      push('0, '0, C_MDROUT | C_IRIN, '0, 1'b1, rbit());
      case (kind(op))
         1: begin
            push('0, oh(rb), C_YIN, '0, 1'b1, rbit());
            push('0, oh(rc), C_ZIN, alu_mask(op), 1'b1, rbit());
            push(oh(ra), '0, C_ZLO, '0, 1'b1, rbit());
            m_ret = m_ret + 1'b1;
         end
         2: begin
            push('0, oh(ra), C_YIN, '0, 1'b1, rbit());
            push('0, oh(rb), C_ZIN, alu_mask(op), 1'b1, rbit());
            push('0, '0, C_ZLO | C_LOIN, '0, 1'b1, rbit());
            push('0, '0, C_ZHI | C_HIIN, '0, 1'b1, rbit());
            m_ret = m_ret + 1'b1;
         end
         3: begin
            push('0, oh(rb), C_ZIN, alu_mask(op), 1'b1, rbit());
            push(oh(ra), '0, C_ZLO, '0, 1'b1, rbit());
            m_ret = m_ret + 1'b1;
         end
         4: begin
            push('0, '0, '0, '0, 1'b1, rbit());
            m_ret = m_ret + 1'b1;
         end
         5: begin
            push('0, '0, '0, '0, 1'b1, rbit());
            push_halt(4);
         end
         default: begin
            push('0, '0, '0, '0, 1'b1, rbit());
            m_err = 1'b1;
         end
      endcase
   endtask

   task automatic run_q();
      rec_t r;
      int   drivers;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clk);
         chk("reg_in", 64'(reg_in), 64'(r.rin));
         chk("reg_out", 64'(reg_out), 64'(r.rout));
         chk("ctl", 64'(ctl), 64'(r.ctl));
         chk("alu_op", 64'(alu_op), 64'(r.alu));
         chk("run", 64'(run), 64'(r.run));
         chk("err", 64'(err), 64'(r.err));
         chk("retired", 64'(retired), 64'(r.ret));
         drivers = $countones(reg_out) + int'(ctl[14]) + int'(ctl[8]) + int'(ctl[6]) +
                   int'(ctl[4]) + int'(ctl[2]) + int'(ctl[1]);
         chk("one_bus_driver", 64'(drivers <= 1), 64'(1));
         mem_ready = r.mr;
         ir = r.ir_next;
      end
   endtask

   task automatic do_reset();
      clr = 1'b1;
      @(negedge clk);
      chk("rst_reg_in", 64'(reg_in), 64'(0));
      chk("rst_reg_out", 64'(reg_out), 64'(0));
      chk("rst_ctl", 64'(ctl), 64'(0));
      chk("rst_alu_op", 64'(alu_op), 64'(0));
      chk("rst_run", 64'(run), 64'(1));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      clr = 1'b0;
      mem_ready = 1'b0;
      m_err = 1'b0;
      m_ret = '0;
   endtask

   function automatic logic [31:0] rand_instr(input logic [4:0] op);
      return {op, 27'($urandom)};
   endfunction

   function automatic logic [4:0] rand_legal();
      logic [4:0] ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
      return ops[$urandom_range(0, 13)];
   endfunction

   function automatic logic [4:0] rand_illegal();
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      while (kind(op) != 0) op = 5'($urandom_range(0, 31));
      return op;
   endfunction

   initial begin
      do_reset();

      // Directed: zero-wait ADD R1,R2,R3 and MUL R4,R5
      build(32'h18918000, 0);
      build(32'h7A280000, 0);
      // Fetch wait of 3 cycles, then the one-short-of-timeout boundary
      build(rand_instr(5'd4), 3);
      build(rand_instr(5'd17), TO - 1);
      // Opcode 11111 faults but execution resumes
      build(rand_instr(5'b11111), 0);
      build(rand_instr(5'd26), 0);
      run_q();

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) build(rand_instr(rand_illegal()), $urandom_range(0, 4));
         else                           build(rand_instr(rand_legal()), $urandom_range(0, 4));
      end
      run_q();

      // clr in the middle of an F2 wait
      build(rand_instr(5'b11100), 0);
      run_q();
      push('0, '0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, '0, 1'b1, 1'b0);
      push('0, '0, C_ZLO | C_PCIN, '0, 1'b1, 1'b0);
      push('0, '0, C_READ | C_MDRIN, '0, 1'b1, 1'b0);
      push('0, '0, C_READ | C_MDRIN, '0, 1'b1, 1'b0);
      run_q();
      do_reset();

      // Counter wrap through NOPs
      for (int i = 0; i < (1 << CW) + 1; i++) build(rand_instr(5'd26), 0);
      run_q();

      // Fetch timeout halts with err
      build(rand_instr(5'd3), TO);
      run_q();
      do_reset();

      // HALT opcode
      build(rand_instr(5'd6), 1);
      build(rand_instr(5'd27), 0);
      run_q();
      do_reset();
      build(rand_instr(5'd16), 2);
      run_q();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
